// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the microwave cook timer: state encodings, BCD limits,
// the M:TS time record and its one-second decrement.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] SEC_MAX  = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_MAX  = 4'd9;

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] tens;
        logic [3:0] sec;
    } mts_t;

    // Modular BCD decrement; the min wrap is never reached because RUN never ticks at 0:00.
    function automatic mts_t mts_dec(input mts_t cur);
        mts_t nxt;
        nxt = cur;
        if (cur.sec != 4'd0) begin
            nxt.sec = cur.sec - 4'd1;
        end else begin
            nxt.sec = SEC_MAX;
            if (cur.tens != 4'd0) begin
                nxt.tens = cur.tens - 4'd1;
            end else begin
                nxt.tens = TENS_MAX;
                nxt.min  = (cur.min == 4'd0) ? MIN_MAX : cur.min - 4'd1;
            end
        end
        return nxt;
    endfunction

    function automatic logic mts_zero(input mts_t v);
        return (v == '0);
    endfunction

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Purpose: divides clk into a one-cycle tick every TICK_DIV cycles; clr holds the count at 0.
// Latency: first tick TICK_DIV cycles after clr drops; tick is combinational from the count register.
// Backpressure: none, free-running while clr is low.
module tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Purpose: microwave cook timer; keypad entry of M:TS, 1 s countdown, done hold. Option: DOOR_INTERLOCK_EN.
// Latency: every strobe takes effect on the next clock edge; all outputs come straight from flops.
// Backpressure: none; strobes outside their valid states are dropped.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV   = 1000,
    parameter int DONE_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_open,
    output logic [3:0] sec,
    output logic [3:0] t,
    output logic [3:0] min,
    output logic       heating,
    output logic       done
);

    localparam int DW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS + 1) : 1;
    localparam logic [DW-1:0] DONE_LAST = DW'(DONE_TICKS - 1);

    state_e        state_q, state_d;
    mts_t          tm_q, tm_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    mts_t          tm_dec;
    logic          tick;
    logic          clr;
    logic          start_ok;
    logic          pause_req;

`ifdef DOOR_INTERLOCK_EN
    assign start_ok  = start && !door_open;
    assign pause_req = stop || door_open;
`else
    logic unused_door;
    assign unused_door = door_open;
    assign start_ok    = start;
    assign pause_req   = stop;
`endif

    // Prescaler also runs in DONE so the done hold is measured in ticks.
    assign clr = (state_q == ST_IDLE) || (state_q == ST_PAUSE);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .tick (tick)
    );

    assign tm_dec = mts_dec(tm_q);

    always_comb begin
        state_d = state_q;
        tm_d    = tm_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (stop) begin
                    tm_d = '0;
                end else if (start_ok && !mts_zero(tm_q)) begin
                    state_d = ST_RUN;
                end else if (digit_valid && (digit <= SEC_MAX) && (tm_q.sec <= TENS_MAX)) begin
                    tm_d = '{min: tm_q.tens, tens: tm_q.sec, sec: digit};
                end
            end
            ST_RUN: begin
                if (pause_req) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    tm_d = tm_dec;
                    if (mts_zero(tm_dec)) begin
                        state_d = ST_DONE;
                        dcnt_d  = '0;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    tm_d    = '0;
                end else if (start_ok) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (dcnt_q == DONE_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tm_q    <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tm_q    <= tm_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign min     = tm_q.min;
    assign t       = tm_q.tens;
    assign sec     = tm_q.sec;
    assign heating = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4, DONE_TICKS=2; inputs change and outputs
// are sampled on the falling edge. Door checks are compiled in with DOOR_INTERLOCK_EN.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       digit_valid;
    logic [3:0] digit;
    logic       start;
    logic       stop;
    logic       door_open;
    logic [3:0] sec;
    logic [3:0] t;
    logic [3:0] min;
    logic       heating;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    countdown_timer #(
        .TICK_DIV  (4),
        .DONE_TICKS(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_valid(digit_valid),
        .digit      (digit),
        .start      (start),
        .stop       (stop),
        .door_open  (door_open),
        .sec        (sec),
        .t          (t),
        .min        (min),
        .heating    (heating),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Time is checked as a 12-bit BCD word {min,t,sec}; state as {heating,done}.
    task automatic chk_time(input string tag, input logic [11:0] exp);
        check(tag, {20'd0, min, t, sec}, {20'd0, exp});
    endtask

    task automatic chk_st(input string tag, input logic [1:0] exp);
        check(tag, {30'd0, heating, done}, {30'd0, exp});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        @(negedge clk);
        digit_valid = 1'b0;
        digit       = 4'd0;
    endtask

    task automatic press_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic press_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; digit_valid = 1'b0; digit = 4'd0;
        start = 1'b0; stop = 1'b0; door_open = 1'b0;
        #1;
        chk_time("reset_time", 12'h000);
        chk_st("reset_state", 2'b00);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Entry and guards
        key(4'd1); key(4'd3); key(4'd0);
        chk_time("entry_130", 12'h130);
        key(4'd7);
        chk_time("entry_307", 12'h307);
        key(4'd8);
        chk_time("guard_sec7", 12'h307);
        press_stop();
        chk_time("idle_stop_clear", 12'h000);
        key(4'd8);
        chk_time("entry_008", 12'h008);
        key(4'd2);
        chk_time("guard_sec8", 12'h008);
        press_stop();
        key(4'd12);
        chk_time("guard_digit12", 12'h000);
        press_start();
        chk_st("start_at_zero", 2'b00);
        key(4'd5);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk_time("stop_beats_start_t", 12'h000);
        chk_st("stop_beats_start_s", 2'b00);

        // Borrow chain
        key(4'd1); key(4'd0); key(4'd0);
        chk_time("load_100", 12'h100);
        press_start();
        chk_st("run_heating", 2'b10);
        idle(3);
        chk_time("before_first_tick", 12'h100);
        idle(1);
        chk_time("borrow_059", 12'h059);
        key(4'd3);
        chk_time("digit_ignored_run", 12'h059);
        idle(35);
        chk_time("after40_050", 12'h050);
        press_stop();
        chk_time("pause_hold_050", 12'h050);
        press_stop();
        chk_time("pause_stop_clear", 12'h000);
        chk_st("pause_stop_idle", 2'b00);

        // Expiry and done hold
        key(4'd2);
        press_start();
        chk_st("exp_run", 2'b10);
        idle(4);
        chk_time("exp_001", 12'h001);
        idle(4);
        chk_time("exp_000", 12'h000);
        chk_st("exp_done", 2'b01);
        idle(7);
        chk_st("done_hold", 2'b01);
        idle(1);
        chk_st("done_to_idle", 2'b00);

        // Pause, resume, tick coinciding with stop
        key(4'd4); key(4'd5);
        press_start();
        press_stop();
        chk_time("pause_045", 12'h045);
        chk_st("pause_state", 2'b00);
        idle(6);
        chk_time("pause_still_045", 12'h045);
        press_start();
        idle(3);
        chk_time("resume_full_second", 12'h045);
        chk_st("resume_run", 2'b10);
        idle(1);
        chk_time("resume_044", 12'h044);
        idle(3);
        press_stop();
        chk_time("stop_on_tick_044", 12'h044);
        chk_st("stop_on_tick_pause", 2'b00);
        press_stop();
        chk_time("pause_clear_000", 12'h000);

        // Asynchronous reset mid-run
        key(4'd2); key(4'd3); key(4'd0);
        press_start();
        idle(5);
        chk_time("run_229", 12'h229);
        #2 rst_n = 1'b0;
        #1;
        chk_time("async_rst_time", 12'h000);
        chk_st("async_rst_state", 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk_st("after_rst_idle", 2'b00);

`ifdef DOOR_INTERLOCK_EN
        key(4'd9);
        press_start();
        door_open = 1'b1;
        idle(1);
        chk_st("door_forces_pause", 2'b00);
        chk_time("door_pause_time", 12'h009);
        press_start();
        chk_st("door_blocks_start", 2'b00);
        door_open = 1'b0;
        press_start();
        chk_st("door_closed_resume", 2'b10);
        press_stop();
        press_stop();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
